// File: rtl/powlib_afifo_rdctrl_pkg.sv
// ---------------------------------------------------------------------------
// powlib_afifo_rdctrl_pkg
// Shared helpers for the async FIFO read-side controller:
//   clog2      - ceiling log2, used to size the RAM index
//   ptrWidth   - pointer width; pointers carry one extra wrap bit (WIDX+1)
//   grayEncode - binary to reflected gray
//   grayDecode - reflected gray to binary
// Ports: none (package).
// ---------------------------------------------------------------------------
package powlib_afifo_rdctrl_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // The extra bit tells a full ring apart from an empty one.
  function automatic int ptrWidth(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic logic [31:0] grayEncode(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] grayDecode(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) bin[i] = bin[i+1] ^ gray[i];
    return bin;
  endfunction

endpackage

// File: rtl/powlib_afifo_rdctrl_if.sv
// ---------------------------------------------------------------------------
// powlib_afifo_rdctrl_if
// Groups the read-side controller's RAM read port and output stream.
//   rdidx  - RAM read index
//   rdrdy  - RAM read enable
//   rddata - RAM read data (registered RAM output, one edge after rdrdy)
//   odata  - output stream data
//   ovld   - output stream valid
//   ordy   - output stream ready
// Modports: master = the controller, slave = RAM plus stream consumer.
// ---------------------------------------------------------------------------
interface powlib_afifo_rdctrl_if
  import powlib_afifo_rdctrl_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 8
);
  localparam int WIDX = clog2(D);

  logic [WIDX-1:0] rdidx;
  logic            rdrdy;
  logic [W-1:0]    rddata;
  logic [W-1:0]    odata;
  logic            ovld;
  logic            ordy;

  modport master (output rdidx, rdrdy, odata, ovld, input rddata, ordy);
  modport slave  (input rdidx, rdrdy, odata, ovld, output rddata, ordy);
endinterface

// File: rtl/powlib_afifo_rdctrl_obuf.sv
// ---------------------------------------------------------------------------
// powlib_afifo_obuf
// Two-entry valid/ready output buffer. The head entry is always presented
// on data_o, so the output stays stable until it is popped.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push_i     - write data_i at this edge (caller guarantees a free slot)
//   data_i     - data to push
//   pop_i      - consume the head at this edge (only while vld_o)
//   data_o     - head entry
//   vld_o      - buffer non-empty
//   bcnt_o     - number of held entries, 0..2
// ---------------------------------------------------------------------------
module powlib_afifo_obuf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         vld_o,
  output logic [1:0]   bcnt_o
);
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   bcnt_q, bcnt_d;

  // Next-state of the two slots. A pop shifts the tail into the head; a
  // push lands in the first free slot, or straight into the head when the
  // only held entry leaves on the same edge, which keeps order intact.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    bcnt_d = bcnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (bcnt_q == 2'd0) head_d = data_i;
        else                tail_d = data_i;
        bcnt_d = bcnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        bcnt_d = bcnt_q - 2'd1;
      end
      2'b11: begin
        if (bcnt_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  // Slot and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      bcnt_q <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign data_o = head_q;
  assign vld_o  = (bcnt_q != 2'd0);
  assign bcnt_o = bcnt_q;
endmodule

// File: rtl/powlib_afifo_rdctrl.sv
// ---------------------------------------------------------------------------
// powlib_afifo_rdctrl
// Read-side controller of an asynchronous FIFO. Owns the binary and gray
// read pointers, synchronises the write pointer into clk, derives empty,
// drives a registered-output RAM read port and presents entries through a
// two-entry output buffer at up to one entry per cycle.
// Ports:
//   clk, rst        - read clock, asynchronous active-high reset
//   wrptr_gray_i    - gray write pointer from the write domain
//   rdptr_gray_o    - registered gray read pointer to the write domain
//   empty_o         - synchronised write pointer equals read pointer
//   rdcnt_o         - entries in RAM not yet issued (0 unless enabled)
//   bus (master)    - RAM read port and output stream
// Optional: define POWLIB_AFIFO_RDCTRL_CNT_EN to build the rdcnt register.
// ---------------------------------------------------------------------------
module powlib_afifo_rdctrl
  import powlib_afifo_rdctrl_pkg::*;
#(
  parameter  int W    = 32,
  parameter  int D    = 8,
  parameter  int S    = 2,
  localparam int WIDX = clog2(D),
  localparam int PW   = ptrWidth(D)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PW-1:0]         wrptr_gray_i,
  output logic [PW-1:0]         rdptr_gray_o,
  output logic                  empty_o,
  output logic [PW-1:0]         rdcnt_o,
  powlib_afifo_rdctrl_if.master bus
);
  logic [PW-1:0] sync_q [S];
  logic [PW-1:0] wsyncBin;
  logic [PW-1:0] rdptrBin_q, rdptrBin_d;
  logic [PW-1:0] rdptrGray_q, rdptrGray_d;
  logic          pend_q, pend_d;
  logic [1:0]    bcnt;
  logic [2:0]    occ;
  logic          pop;
  logic          empty;
  logic          rdrdy;

  // Write-pointer synchroniser: a plain flop chain. Gray coding keeps any
  // metastable sample within one step of the true pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wrptr_gray_i;
      for (int i = 1; i < S; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wsyncBin = PW'(grayDecode(32'(sync_q[S-1])));
  assign empty    = (wsyncBin == rdptrBin_q);
  assign pop      = bus.ovld && bus.ordy;

  // Issue decision. Entries already buffered plus the one returning from
  // the RAM, minus the one leaving now, must leave room for one more.
  always_comb begin
    occ   = {1'b0, bcnt} + {2'b00, pend_q} - {2'b00, pop};
    rdrdy = !empty && (occ < 3'd2);
  end

  // Pointer advance on issue; the gray copy is encoded from the next binary
  // value so the registered gray output flips exactly one bit per issue.
  always_comb begin
    rdptrBin_d = rdptrBin_q;
    pend_d     = 1'b0;
    if (rdrdy) begin
      rdptrBin_d = rdptrBin_q + PW'(1);
      pend_d     = 1'b1;
    end
    rdptrGray_d = PW'(grayEncode(32'(rdptrBin_d)));
  end

  // Read pointer and in-flight flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdptrBin_q  <= '0;
      rdptrGray_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      rdptrBin_q  <= rdptrBin_d;
      rdptrGray_q <= rdptrGray_d;
      pend_q      <= pend_d;
    end
  end

  powlib_afifo_obuf #(.W(W)) outBuf (
    .clk    (clk),
    .rst    (rst),
    .push_i (pend_q),
    .data_i (bus.rddata),
    .pop_i  (pop),
    .data_o (bus.odata),
    .vld_o  (bus.ovld),
    .bcnt_o (bcnt)
  );

`ifdef POWLIB_AFIFO_RDCTRL_CNT_EN
  logic [PW-1:0] rdcnt_q;

  // Occupancy of the RAM as seen from this domain; the wrap bit makes the
  // modular difference cover the full 0..D range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdcnt_q <= '0;
    else     rdcnt_q <= wsyncBin - rdptrBin_q;
  end

  assign rdcnt_o = rdcnt_q;
`else
  assign rdcnt_o = '0;
`endif

  assign bus.rdidx    = rdptrBin_q[WIDX-1:0];
  assign bus.rdrdy    = rdrdy;
  assign rdptr_gray_o = rdptrGray_q;
  assign empty_o      = empty;
endmodule

// File: tb/tb_powlib_afifo_rdctrl.sv
// ---------------------------------------------------------------------------
// tb_powlib_afifo_rdctrl
// Bench for the async FIFO read controller (W=32, D=8, S=2). The bench
// plays the write domain and the registered-output RAM (mem[i]=A0000000+i).
// ---------------------------------------------------------------------------
module tb_powlib_afifo_rdctrl;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int S  = 2;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] wrptrGray = '0;
  logic [PW-1:0] wrBin = '0;
  logic [PW-1:0] rdptrGray;
  logic [PW-1:0] rdcnt;
  logic          empty;

  logic [31:0] mem [D];
  logic [31:0] expQ [$];

  int vectors = 0;
  int miscompares = 0;
  int popCount = 0;
  int rdrdyCount = 0;
  int runLen = 0;
  int maxRun = 0;
  int lastIdx = -1;
  bit idxWrapSeen = 1'b0;
  bit ptrWrapSeen = 1'b0;
  logic [PW-1:0] prevGray = '0;

  powlib_afifo_rdctrl_if #(.W(W), .D(D)) bus ();

  powlib_afifo_rdctrl #(.W(W), .D(D), .S(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrptr_gray_i (wrptrGray),
    .rdptr_gray_o (rdptrGray),
    .empty_o      (empty),
    .rdcnt_o      (rdcnt),
    .bus          (bus)
  );

  // Free-running read clock.
  always #5 clk = ~clk;

  // Registered-output RAM model.
  initial begin
    for (int i = 0; i < D; i++) mem[i] = 32'hA000_0000 + i;
    bus.ordy = 1'b0;
  end

  always @(posedge clk) begin
    if (bus.rdrdy) bus.rddata <= mem[bus.rdidx];
  end

  function automatic logic [PW-1:0] toGray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Write one entry per cycle and queue its expected read-back value.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back(32'hA000_0000 + {29'd0, wrBin[2:0]});
      wrBin     = wrBin + 4'd1;
      wrptrGray = toGray(wrBin);
      @(posedge clk); #1;
    end
  endtask

  task automatic waitVld(input int budget);
    int c = 0;
    while (!bus.ovld && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (!bus.ovld) timeoutFail("waitVld");
  endtask

  task automatic waitDrained(input int budget);
    int c = 0;
    while (!(empty && !bus.ovld && expQ.size() == 0) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (!(empty && !bus.ovld && expQ.size() == 0)) timeoutFail("waitDrained");
  endtask

  // Monitor: scoreboard compare on every pop, plus bookkeeping of issue
  // pulses, valid runs and wrap events, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.pend_q) checkOutput("bufNoOverflow", {31'd0, dut.bcnt == 2'd2}, 32'd0);
      if (bus.ovld && bus.ordy) begin
        popCount++;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL odata: unexpected beat %h, nothing expected", bus.odata);
        end else begin
          checkOutput("odata", bus.odata, expQ.pop_front());
        end
      end
      if (bus.rdrdy) begin
        rdrdyCount++;
        if (lastIdx == 7 && bus.rdidx == 3'd0) idxWrapSeen = 1'b1;
        lastIdx = int'(bus.rdidx);
      end
      if (bus.ovld) begin
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      if (prevGray == 4'b1000 && rdptrGray == 4'b0000) ptrWrapSeen = 1'b1;
      prevGray = rdptrGray;
    end
  end

  initial begin
    int p0;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOvld", {31'd0, bus.ovld}, 32'd0);
    checkOutput("rstRdrdy", {31'd0, bus.rdrdy}, 32'd0);
    checkOutput("rstEmpty", {31'd0, empty}, 32'd1);
    checkOutput("rstRdidx", {29'd0, bus.rdidx}, 32'd0);
    checkOutput("rstOdata", bus.odata, 32'd0);
    checkOutput("rstRdcnt", {28'd0, rdcnt}, 32'd0);
    checkOutput("rstRdptrGray", {28'd0, rdptrGray}, 32'd0);
    rst = 1'b0;

    // Single entry: S+2 edges from write pointer to valid output.
    @(posedge clk); #1;
    bus.ordy = 1'b1;
    expQ.push_back(32'hA000_0000);
    wrBin = 4'd1;
    wrptrGray = 4'd1;
    @(posedge clk); #1;
    checkOutput("singleEmptyK", {31'd0, empty}, 32'd1);
    @(posedge clk); #1;
    checkOutput("singleEmptyK1", {31'd0, empty}, 32'd0);
    checkOutput("singleRdrdyK1", {31'd0, bus.rdrdy}, 32'd1);
    checkOutput("singleRdidxK1", {29'd0, bus.rdidx}, 32'd0);
    @(posedge clk); #1;
    checkOutput("singleRdptrGray", {28'd0, rdptrGray}, 32'd1);
    checkOutput("singleEmptyK2", {31'd0, empty}, 32'd1);
    checkOutput("singleOvldK2", {31'd0, bus.ovld}, 32'd0);
    @(posedge clk); #1;
    checkOutput("singleOvldK3", {31'd0, bus.ovld}, 32'd1);
    checkOutput("singleOdataK3", bus.odata, 32'hA000_0000);
    @(posedge clk); #1;
    checkOutput("singleOvldK4", {31'd0, bus.ovld}, 32'd0);

    // Reset mid-stream while an entry is being held.
    bus.ordy = 1'b0;
    applyStimulus(3);
    waitVld(20);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstOvld", {31'd0, bus.ovld}, 32'd0);
    checkOutput("midRstRdrdy", {31'd0, bus.rdrdy}, 32'd0);
    checkOutput("midRstEmpty", {31'd0, empty}, 32'd1);
    checkOutput("midRstRdptrGray", {28'd0, rdptrGray}, 32'd0);
    checkOutput("midRstRdidx", {29'd0, bus.rdidx}, 32'd0);
    expQ.delete();
    wrBin = '0;
    wrptrGray = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    prevGray = '0;

    // Stream of 8 at full rate.
    bus.ordy = 1'b1;
    maxRun = 0;
    p0 = popCount;
    applyStimulus(8);
    checkOutput("streamWrGray", {28'd0, wrptrGray}, 32'h0000_000C);
    waitDrained(60);
    checkOutput("streamRun", maxRun, 32'd8);
    checkOutput("streamPops", popCount - p0, 32'd8);
    checkOutput("streamEmpty", {31'd0, empty}, 32'd1);
    checkOutput("streamRdptrGray", {28'd0, rdptrGray}, 32'h0000_000C);

    // Backpressure: only two fetches while the consumer stalls.
    bus.ordy = 1'b0;
    rdrdyCount = 0;
    p0 = popCount;
    applyStimulus(8);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(posedge clk);
      #1;
      checkOutput("bpHeldOdata", bus.odata, 32'hA000_0000);
      checkOutput("bpHeldOvld", {31'd0, bus.ovld}, 32'd1);
    end
    checkOutput("bpRdrdyPulses", rdrdyCount, 32'd2);
    bus.ordy = 1'b1;
    waitDrained(80);
    checkOutput("bpPops", popCount - p0, 32'd8);

    // Wrap: 20 entries in bursts of 5.
    p0 = popCount;
    idxWrapSeen = 1'b0;
    ptrWrapSeen = 1'b0;
    lastIdx = -1;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(5);
      waitDrained(60);
    end
    checkOutput("wrapPops", popCount - p0, 32'd20);
    checkOutput("wrapIdxSeen", {31'd0, idxWrapSeen}, 32'd1);
    checkOutput("wrapPtrSeen", {31'd0, ptrWrapSeen}, 32'd1);
    checkOutput("wrapRdptrGray", {28'd0, rdptrGray}, 32'h0000_0006);
    checkOutput("wrapRdidx", {29'd0, bus.rdidx}, 32'd4);

    // Occupancy: five written, two fetched, consumer stalled.
    bus.ordy = 1'b0;
    applyStimulus(5);
    repeat (8) @(posedge clk);
    #1;
`ifdef POWLIB_AFIFO_RDCTRL_CNT_EN
    checkOutput("rdcnt", {28'd0, rdcnt}, 32'd3);
`else
    checkOutput("rdcnt", {28'd0, rdcnt}, 32'd0);
`endif
    checkOutput("cntRdrdy", {31'd0, bus.rdrdy}, 32'd0);
    checkOutput("cntOdata", bus.odata, 32'hA000_0004);
    bus.ordy = 1'b1;
    waitDrained(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end
endmodule

// File: doc/powlib_afifo_rdctrl.md
Name: powlib_afifo_rdctrl

Overview:
Read-side controller of an asynchronous FIFO; it is the reader counterpart to a write-domain pointer/full controller. It owns the binary and gray read pointers, synchronises the incoming gray write pointer into clk, and derives empty. It drives the read port of a dual-port RAM configured with registered output (1-cycle read latency). It presents entries on a valid/ready stream through a 2-entry output buffer, sustaining 1 entry/cycle.

Parameters:
W, 32, data width
D, 8, FIFO depth; power of 2, >=2
WIDX, clog2(D), RAM index width; pointers are WIDX+1 bits
S, 2, synchroniser stages for wrptr_gray; >=1

Ports:
clk  in  1  read-domain clock
rst  in  1  reset, asynchronous, active-high
wrptr_gray  in  WIDX+1  gray write pointer from write domain, registered there
rdptr_gray  out  WIDX+1  registered gray read pointer to write domain
rdidx  out  WIDX  RAM read index = rdptr_bin[WIDX-1:0]
rdrdy  out  1  RAM read enable (issue)
rddata  in  W  RAM read data, valid one edge after rdrdy
odata  out  W  output data (buffer head)
ovld  out  1  output valid
ordy  in  1  output ready
empty  out  1  synchronised write pointer equals read pointer
rdcnt  out  WIDX+1  occupancy; see Optional Feature

Behaviour:
- Reset (async, immediate): all sync stages=0, rdptr_bin=0, rdptr_gray=0, pend=0, buffer count=0. Outputs: ovld=0, rdrdy=0, empty=1, rdidx=0, odata=0, rdcnt=0.
- Sync: wrptr_gray passes through S async-reset flops. wsync_bin = graydecode(last stage).
- empty = (wsync_bin == rdptr_bin), combinational from registers.
- pop = ovld && ordy. bcnt = buffer count in 0..2. pend = read issued last cycle.
- Issue rule: rdrdy = !empty && (bcnt + pend - pop) < 2. rdrdy is combinational.
- On issue: rdptr_bin += 1 (mod 2^(WIDX+1)). rdptr_gray <= grayencode(rdptr_bin+1) on the same edge. pend <= 1, else pend <= 0.
- Capture: when pend=1, rddata is pushed into the buffer at that edge.
- Buffer is a 2-entry FIFO; odata = head; ovld = (bcnt != 0).
- Simultaneous push and pop: bcnt unchanged and order is preserved. Pop without push frees a slot.
- The issue rule guarantees no overflow. Buffer push with bcnt=2 is impossible; the bench asserts this.
- Latency: wrptr_gray stable before edge k gives empty=0 after edge k+S-1 and rdrdy high in the following cycle. The RAM samples at edge k+S. Capture at k+S+1 sets ovld=1, i.e. S+2 edges total.
- Throughput: with ordy held 1, one entry/cycle sustained.
- Backpressure: with ordy=0, at most 2 entries are fetched. odata and ovld are held stable until pop.
- Wrap-around: pointers carry an extra wrap bit. rdidx wraps D-1 to 0; the pointer wraps 2D-1 to 0.
- The write side is responsible for never overrunning. rdptr_gray changes at most one bit per edge.
- Reset mid-operation discards buffered and in-flight data. The write domain must be reset in the same window.

Optional Feature:
- Macro: POWLIB_AFIFO_RDCTRL_CNT_EN.
- Defined: rdcnt is a register updated every edge to (wsync_bin - rdptr_bin) mod 2^(WIDX+1). It counts RAM-resident entries not yet issued, range 0..D.
- Undefined: rdcnt is tied to 0 and no subtractor is built.

Decomposition:
- Shared package/header: clog2, grayencode and graydecode functions, and the pointer-width rule WIDX+1.
- Sub-module: powlib_afifo_obuf, a 2-entry valid/ready output buffer with push/pop and bcnt output.
- The synchroniser chain is a plain flop chain inside the top; no separate module.

Test Plan:
- Config for all scenarios: W=32, D=8, S=2; the RAM model returns mem[i]=32'hA000_0000+i.
- Reset: assert rst mid-stream with ovld=1 -> immediately ovld=0, rdrdy=0, empty=1, rdptr_gray=0, rdidx=0.
- Single entry: wrptr_gray 0->1 before edge k, ordy=1 -> ovld=1 after edge k+3 with odata=A0000000. It drops the next cycle; rdptr_gray=1.
- Stream: wrptr_gray stepped to gray(8)=4'b1100, ordy=1 -> 8 consecutive ovld cycles with odata A0000000..A0000007. Then empty=1, rdptr_gray=4'b1100.
- Backpressure: 8 entries, ordy=0 -> exactly 2 rdrdy pulses, then odata held at A0000000. Releasing ordy yields 8 beats with no loss or duplicate.
- Wrap: 20 entries fed in bursts of 5 -> rdidx wraps 7->0 and the pointer wraps 15->0. Output order is correct; final rdptr_gray=gray(4).
- CNT_EN: macro defined, wrptr=gray(5), ordy=0 -> rdcnt settles at 3 (5 minus 2 fetched). Macro undefined -> rdcnt=0.
